// File: rtl/decode_stage.sv
// RV32I decode stage: turns a fetched {pc, instr} pair into register indices,
// a sign-extended immediate, an ALU operation and control flags, and registers
// the result for execute behind a valid/ready handshake with flush support.
module decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic [2:0]      out_funct3,
    output logic [3:0]      out_class,
    output logic            out_reg_write,
    output logic            out_illegal
);

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    typedef enum logic [3:0] {
        ClsNone   = 4'd0,
        ClsLui    = 4'd1,
        ClsAuipc  = 4'd2,
        ClsJal    = 4'd3,
        ClsJalr   = 4'd4,
        ClsBranch = 4'd5,
        ClsLoad   = 4'd6,
        ClsStore  = 4'd7,
        ClsOpImm  = 4'd8,
        ClsOp     = 4'd9,
        ClsFence  = 4'd10,
        ClsSystem = 4'd11
    } class_e;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcFence  = 7'b0001111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [XLEN-1:0] InstrEcall  = 32'h0000_0073;
    localparam logic [XLEN-1:0] InstrEbreak = 32'h0010_0073;

    localparam logic [6:0] Funct7Zero = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    // Register/ALU op for OP and OP_IMM; alt selects SUB/SRA for funct3 000/101.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    // Raw instruction fields.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_field;
    logic [4:0] rs1_field;
    logic [4:0] rs2_field;

    assign opcode    = in_instr[6:0];
    assign funct3    = in_instr[14:12];
    assign funct7    = in_instr[31:25];
    assign rd_field  = in_instr[11:7];
    assign rs1_field = in_instr[19:15];
    assign rs2_field = in_instr[24:20];

    // Immediate formats, all sign-extended from instr[31].
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'h000};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    // Decoded (pre-register) values.
    class_e          dec_class;
    alu_op_e         dec_alu;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic [4:0]      dec_rd;
    logic            dec_reg_write;

    // Combinational decode of the instruction currently offered by fetch.
    always_comb begin
        dec_class     = ClsNone;
        dec_alu       = AluAdd;
        dec_imm       = '0;
        dec_illegal   = 1'b0;
        dec_rd        = rd_field;
        dec_reg_write = 1'b0;

        case (opcode)
            OpcLui: begin
                dec_class = ClsLui;
                dec_alu   = AluPassB;
                dec_imm   = imm_u;
            end
            OpcAuipc: begin
                dec_class = ClsAuipc;
                dec_imm   = imm_u;
            end
            OpcJal: begin
                dec_class = ClsJal;
                dec_imm   = imm_j;
            end
            OpcJalr: begin
                dec_class   = ClsJalr;
                dec_imm     = imm_i;
                dec_illegal = (funct3 != 3'b000);
            end
            OpcBranch: begin
                dec_class   = ClsBranch;
                dec_alu     = AluSub;
                dec_imm     = imm_b;
                dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OpcLoad: begin
                dec_class   = ClsLoad;
                dec_imm     = imm_i;
                dec_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OpcStore: begin
                dec_class   = ClsStore;
                dec_imm     = imm_s;
                dec_illegal = (funct3 > 3'b010);
            end
            OpcOpImm: begin
                dec_class = ClsOpImm;
                dec_imm   = imm_i;
                // ADDI has no subtract form; only the shift-right slot uses funct7.
                dec_alu   = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001) begin
                    dec_illegal = (funct7 != Funct7Zero);
                end else if (funct3 == 3'b101) begin
                    dec_illegal = (funct7 != Funct7Zero) && (funct7 != Funct7Alt);
                end
            end
            OpcOp: begin
                dec_class = ClsOp;
                dec_alu   = alu_from_funct3(funct3, funct7 == Funct7Alt);
                if (funct7 == Funct7Alt) begin
                    dec_illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                end else begin
                    dec_illegal = (funct7 != Funct7Zero);
                end
            end
            OpcFence: begin
                dec_class = ClsFence;
            end
            OpcSystem: begin
                dec_class   = ClsSystem;
                dec_imm     = imm_i;
                dec_illegal = (in_instr != InstrEcall) && (in_instr != InstrEbreak);
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase

        // Compressed/unaligned encodings are never legal here.
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end

        if (dec_illegal) begin
            dec_class = ClsNone;
            dec_alu   = AluAdd;
            dec_imm   = '0;
            dec_rd    = '0;
        end

        dec_reg_write = (dec_rd != 5'd0) &&
                        (dec_class inside {ClsLui, ClsAuipc, ClsJal, ClsJalr,
                                           ClsLoad, ClsOpImm, ClsOp});
    end

    // Pipeline register state.
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [4:0]      rd_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [XLEN-1:0] imm_q;
    logic [3:0]      alu_q;
    logic [2:0]      funct3_q;
    logic [3:0]      class_q;
    logic            reg_write_q;
    logic            illegal_q;

    logic accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Output register: flush beats accept; drain when execute takes the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            alu_q       <= '0;
            funct3_q    <= '0;
            class_q     <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q     <= 1'b1;
            pc_q        <= in_pc;
            rd_q        <= dec_rd;
            rs1_q       <= rs1_field;
            rs2_q       <= rs2_field;
            imm_q       <= dec_imm;
            alu_q       <= dec_alu;
            funct3_q    <= funct3;
            class_q     <= dec_class;
            reg_write_q <= dec_reg_write;
            illegal_q   <= dec_illegal;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_rd        = rd_q;
    assign out_rs1       = rs1_q;
    assign out_rs2       = rs2_q;
    assign out_imm       = imm_q;
    assign out_alu_op    = alu_q;
    assign out_funct3    = funct3_q;
    assign out_class     = class_q;
    assign out_reg_write = reg_write_q;
    assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// instruction/handshake traffic compared against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic [3:0]  out_alu_op;
    logic [2:0]  out_funct3;
    logic [3:0]  out_class;
    logic        out_reg_write;
    logic        out_illegal;

    decode_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_instr      (in_instr),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_imm       (out_imm),
        .out_alu_op    (out_alu_op),
        .out_funct3    (out_funct3),
        .out_class     (out_class),
        .out_reg_write (out_reg_write),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode, computed from the ISA rules rather than bit concatenation.
    typedef struct {
        int unsigned cls;
        int unsigned alu;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t        d;
        int unsigned alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [6:0]  opc = i[6:0];
        int unsigned f3  = int'(i[14:12]);
        int unsigned f7  = int'(i[31:25]);
        logic [31:0] imm_i = 32'($signed(i) >>> 20);
        int          b;
        int          j;
        b = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        j = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
            + int'(i[30:21]) * 2;
        d.cls = 0; d.alu = 0; d.imm = 0; d.ill = 1'b0; d.rd = i[11:7];
        case (opc)
            7'h37: begin d.cls = 1; d.alu = 10; d.imm = i & 32'hFFFF_F000; end
            7'h17: begin d.cls = 2; d.imm = i & 32'hFFFF_F000; end
            7'h6F: begin d.cls = 3; d.imm = 32'(j); end
            7'h67: begin d.cls = 4; d.imm = imm_i; d.ill = (f3 != 0); end
            7'h63: begin d.cls = 5; d.alu = 1; d.imm = 32'(b); d.ill = (f3 == 2 || f3 == 3); end
            7'h03: begin
                d.cls = 6; d.imm = imm_i;
                d.ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            7'h23: begin
                d.cls = 7; d.imm = (imm_i & ~32'd31) | 32'(i[11:7]); d.ill = (f3 > 2);
            end
            7'h13: begin
                d.cls = 8; d.imm = imm_i; d.alu = alu_tab[f3];
                if (f3 == 5 && f7 == 32) d.alu = 7;
                d.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
            end
            7'h33: begin
                d.cls = 9; d.alu = alu_tab[f3];
                if (f7 == 32) begin
                    if (f3 == 0) d.alu = 1;
                    else if (f3 == 5) d.alu = 7;
                    else d.ill = 1'b1;
                end else if (f7 != 0) begin
                    d.ill = 1'b1;
                end
            end
            7'h0F: d.cls = 10;
            7'h73: begin
                d.cls = 11; d.imm = imm_i; d.ill = !(i == 32'h73 || i == 32'h0010_0073);
            end
            default: d.ill = 1'b1;
        endcase
        if (i[1:0] != 2'b11) d.ill = 1'b1;
        if (d.ill) begin
            d.cls = 0; d.rd = 0;
        end
        d.rw = (d.rd != 0) && (d.cls inside {1, 2, 3, 4, 6, 8, 9});
        return d;
    endfunction

    // Model of the registered entry.
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_ins   = '0;

    task automatic check_outputs();
        dec_t d;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            d = ref_decode(m_ins);
            check("out_pc", out_pc, m_pc);
            check("out_rs1", 32'(out_rs1), 32'(m_ins[19:15]));
            check("out_rs2", 32'(out_rs2), 32'(m_ins[24:20]));
            check("out_funct3", 32'(out_funct3), 32'(m_ins[14:12]));
            check("out_rd", 32'(out_rd), 32'(d.rd));
            check("out_class", 32'(out_class), d.cls);
            check("out_reg_write", 32'(out_reg_write), 32'(d.rw));
            check("out_illegal", 32'(out_illegal), 32'(d.ill));
            if (!d.ill) check("out_imm", out_imm, d.imm);
            if (!d.ill && d.cls >= 1 && d.cls <= 9) check("out_alu_op", 32'(out_alu_op), d.alu);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_pc"}, out_pc, 32'd0);
        check({tag, "_imm"}, out_imm, 32'd0);
        check({tag, "_fields"}, 32'({out_rd, out_rs1, out_rs2, out_funct3}), 32'd0);
        check({tag, "_ctl"}, 32'({out_alu_op, out_class, out_reg_write, out_illegal}), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        logic exp_ready;
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
        #1;
        exp_ready = !m_valid || ordy;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (fl) begin
            m_valid = 1'b0;
        end else if (v && exp_ready) begin
            m_valid = 1'b1; m_pc = pc; m_ins = ins;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0]  opc_tab [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                      7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [31:0] ins = $urandom;
        case ($urandom_range(0, 15))
            0: ins = 32'h0000_0000;
            1: ins = 32'hFFFF_FFFF;
            2: ;
            3: ins = $urandom_range(0, 1) ? 32'h0000_0073 : 32'h0010_0073;
            default: begin
                ins[6:0] = opc_tab[$urandom_range(0, 10)];
                case ($urandom_range(0, 2))
                    0: ins[31:25] = 7'h00;
                    1: ins[31:25] = 7'h20;
                    default: ;
                endcase
            end
        endcase
        return ins;
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Directed sequence.
        cycle(1'b1, 32'h100, 32'h0050_0093, 1'b1, 1'b0);
        check("tp_addi_class", 32'(out_class), 32'd8);
        check("tp_addi_imm", out_imm, 32'd5);
        check("tp_addi_rw", 32'(out_reg_write), 32'd1);
        cycle(1'b1, 32'h104, 32'h4020_81B3, 1'b1, 1'b0);
        check("tp_sub_alu", 32'(out_alu_op), 32'd1);
        check("tp_sub_regs", 32'({out_rd, out_rs1, out_rs2}), 32'({5'd3, 5'd1, 5'd2}));
        cycle(1'b1, 32'h108, 32'hFE20_8CE3, 1'b1, 1'b0);
        check("tp_beq_imm", out_imm, 32'hFFFF_FFF8);
        check("tp_beq_class", 32'(out_class), 32'd5);
        cycle(1'b1, 32'h10C, 32'h1234_52B7, 1'b1, 1'b0);
        check("tp_lui_imm", out_imm, 32'h1234_5000);
        check("tp_lui_alu", 32'(out_alu_op), 32'd10);
        cycle(1'b1, 32'h110, 32'h0000_0000, 1'b1, 1'b0);
        check("tp_zero_illegal", 32'({out_valid, out_illegal, out_reg_write}), 32'b110);
        check("tp_zero_pc", out_pc, 32'h110);

        // Back-pressure hold, then release without a bubble.
        cycle(1'b1, 32'h200, 32'h0050_0093, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h204, 32'h00A0_0113, 1'b0, 1'b0);
        check("tp_hold_pc", out_pc, 32'h200);
        cycle(1'b1, 32'h204, 32'h00A0_0113, 1'b1, 1'b0);
        check("tp_release_pc", out_pc, 32'h204);

        // Flush beats a simultaneous accept.
        cycle(1'b1, 32'h300, 32'h0050_0093, 1'b1, 1'b1);
        check("tp_flush_valid", 32'(out_valid), 32'd0);
        cycle(1'b1, 32'h304, 32'h0050_0093, 1'b1, 1'b0);
        check("tp_after_flush_pc", out_pc, 32'h304);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        m_valid = 1'b0;
        cycle(1'b0, 32'h400, 32'h0050_0093, 1'b1, 1'b0);
        check("tp_post_reset_idle", 32'(out_valid), 32'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, gen_instr(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage of the RV32I core; sits directly downstream of instruction fetch.
- Consumes the fetched {pc, instr} pair and decodes it into register indices, a sign-extended immediate, an ALU operation and control flags.
- Registers the result for the execute stage behind a valid/ready handshake, with flush support for branch redirects.

Parameters:
XLEN, 32, datapath width of pc, instr and imm (only 32 is supported)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
in_valid  input  1  fetch output holds a valid instruction
in_ready  output  1  stage can accept an input this cycle
in_pc  input  32  pc of the fetched instruction
in_instr  input  32  raw instruction word
flush  input  1  discard the held entry and any input accepted this cycle
out_valid  output  1  decoded entry valid
out_ready  input  1  execute stage accepts the entry
out_pc  output  32  registered pc
out_rd  output  5  destination register
out_rs1  output  5  source register 1
out_rs2  output  5  source register 2
out_imm  output  32  sign-extended immediate
out_alu_op  output  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
out_funct3  output  3  funct3, passed through for branch/load/store width
out_class  output  4  0 NONE, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OP_IMM, 9 OP, 10 FENCE, 11 SYSTEM
out_reg_write  output  1  writes rd
out_illegal  output  1  illegal instruction; trap downstream

Behaviour:
- Reset (async assert): out_valid=0 and every other registered output = 0. out_class=NONE. in_ready=1 after reset.
- in_ready = !out_valid || out_ready. This is combinational; no bubble is added on back-to-back transfers.
- Accept: when in_valid && in_ready at a posedge, all out_* load from decode(in_pc, in_instr) and out_valid=1. Latency is exactly 1 cycle.
- Hold:
  - out_valid && !out_ready: all out_* stay stable and in_instr is ignored.
  - When no accept occurs and out_ready=1, out_valid drops to 0; payload may hold stale values.
- Flush: at a posedge with flush=1, out_valid becomes 0 regardless of in_valid, in_ready or out_ready. Flush has priority over accept.
- Opcode to class mapping (instr[6:0]):
  - 0110111 LUI, alu PASS_B.
  - 0010111 AUIPC, alu ADD.
  - 1101111 JAL.
  - 1100111 JALR; funct3 must be 000.
  - 1100011 BRANCH; funct3 010 and 011 are illegal.
  - 0000011 LOAD; funct3 in {000,001,010,100,101}.
  - 0100011 STORE; funct3 in {000,001,010}.
  - 0010011 OP_IMM.
  - 0110011 OP.
  - 0001111 FENCE.
  - 1110011 SYSTEM; only 0x00000073 (ECALL) and 0x00100073 (EBREAK) are legal.
- Any other opcode, or instr[1:0] != 11, is illegal. 0x00000000 and 0xFFFFFFFF are illegal.
- OP: funct7 must be 0000000, or 0100000 only with funct3 000 (SUB) or 101 (SRA). Otherwise illegal.
- OP_IMM shifts: funct3 001 requires funct7=0000000. funct3 101 requires 0000000 (SRLI) or 0100000 (SRAI).
- Immediate formats, all sign-extended from instr[31]:
  - I: JALR, LOAD, OP_IMM, SYSTEM.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI, AUIPC; low 12 bits zero.
  - J: JAL, bit0=0.
  - OP and FENCE: imm=0.
- ALU op:
  - LOAD, STORE, JAL, JALR: ADD.
  - BRANCH: SUB.
  - OP and OP_IMM: from funct3/funct7.
- out_reg_write = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP when rd != 0; otherwise 0.
- Illegal entries:
  - out_illegal=1, out_class=NONE, out_reg_write=0, out_rd=0.
  - out_valid still asserts so execute can trap; out_pc is preserved.
- rs1, rs2 and rd are always the raw fields instr[19:15], instr[24:20] and instr[11:7], except rd is forced to 0 when illegal.
- Reset asserted mid-handshake drops the held entry immediately; nothing is emitted after reset deasserts until a new accept.

Test Plan:
- Reset, then in_pc=0x100, instr=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle: out_valid=1, class OP_IMM, rd=1, rs1=0, imm=5, alu ADD, reg_write=1, out_pc=0x100.
- instr=0x402081B3 (sub x3,x1,x2) -> class OP, rd=3, rs1=1, rs2=2, alu SUB; then 0xFE208CE3 (beq x1,x2,-8) -> class BRANCH, imm=0xFFFFFFF8, reg_write=0.
- instr=0x123452B7 (lui x5,0x12345) -> imm=0x12345000, alu PASS_B; then 0x00000000 -> out_valid=1, illegal=1, reg_write=0, rd=0.
- Accept addi, hold out_ready=0 for 3 cycles while presenting a new instr -> in_ready=0, outputs unchanged; raise out_ready -> new instr loads the next cycle with no bubble.
- Present valid input with flush=1 on the same posedge while out_valid=1 -> next cycle out_valid=0; the following accept proceeds normally.
- Assert reset asynchronously between clock edges with out_valid=1 -> out_valid=0 and all outputs 0 before the next edge.
